// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encoding, parity select and line levels.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte request / serial line bundle between the system controller and the UART transmitter.
interface uart_tx_serializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic                  tx_out;
   logic                  busy;

   modport master (
      output p_data, data_valid, par_en, par_typ,
      input  tx_out, busy
   );

   modport slave (
      input  p_data, data_valid, par_en, par_typ,
      output tx_out, busy
   );
endinterface

// File: rtl/uart_tx_parity.sv
// Parity generator: XOR reduction of the payload, inverted for odd parity.
// Kept separate so the receive side can reuse it for checking.
module uart_tx_parity
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  par_bit
);

   assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, LSB-first payload, optional parity, stop bit.
// One i_clk cycle is one bit period; all outputs come straight from registers.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   uart_tx_serializer_if.slave   bus
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [2:0]            state_reg,   state_next;
   logic [CNT_W-1:0]      cnt_reg,     cnt_next;
   logic [DATA_WIDTH-1:0] data_reg,    data_next;
   logic                  par_en_reg,  par_en_next;
   logic                  par_typ_reg, par_typ_next;
   logic                  tx_reg,      tx_next;
   logic                  busy_reg,    busy_next;

   logic                  par_bit;
   logic [CNT_W-1:0]      cnt_inc;

   assign cnt_inc = cnt_reg + CNT_W'(1);

   uart_tx_parity #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data    (data_reg),
      .par_typ (par_typ_reg),
      .par_bit (par_bit)
   );

   // Next-state logic computes the line level for the *coming* bit period,
   // so the start bit appears in the same edge that accepts the byte.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      data_next    = data_reg;
      par_en_next  = par_en_reg;
      par_typ_next = par_typ_reg;
      tx_next      = tx_reg;
      busy_next    = busy_reg;

      case (state_reg)
         ST_IDLE: begin
            tx_next   = LINE_IDLE;
            busy_next = 1'b0;
            if (bus.data_valid) begin
               data_next    = bus.p_data;
               par_en_next  = bus.par_en;
               par_typ_next = bus.par_typ;
               state_next   = ST_START;
               tx_next      = 1'b0;
               busy_next    = 1'b1;
            end
         end
         ST_START: begin
            state_next = ST_DATA;
            cnt_next   = '0;
            tx_next    = data_reg[0];
         end
         ST_DATA: begin
            if (cnt_reg == CNT_LAST) begin
               if (par_en_reg) begin
                  state_next = ST_PARITY;
                  tx_next    = par_bit;
               end else begin
                  state_next = ST_STOP;
                  tx_next    = LINE_IDLE;
               end
            end else begin
               cnt_next = cnt_inc;
               tx_next  = data_reg[cnt_inc];
            end
         end
         ST_PARITY: begin
            state_next = ST_STOP;
            tx_next    = LINE_IDLE;
         end
         ST_STOP: begin
            state_next = ST_IDLE;
            tx_next    = LINE_IDLE;
            busy_next  = 1'b0;
         end
         default: begin
            state_next = ST_IDLE;
            tx_next    = LINE_IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         data_reg    <= '0;
         par_en_reg  <= 1'b0;
         par_typ_reg <= 1'b0;
         tx_reg      <= LINE_IDLE;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         data_reg    <= data_next;
         par_en_reg  <= par_en_next;
         par_typ_reg <= par_typ_next;
         tx_reg      <= tx_next;
         busy_reg    <= busy_next;
      end
   end

   assign bus.tx_out = tx_reg;
   assign bus.busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames,
// a line monitor captures each frame from its start bit and compares.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   typedef struct {
      logic [15:0] bits;
      int          len;
      int          gap;
      bit          abort;
   } frame_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] drv_data    = 8'h00;
   logic       drv_valid   = 1'b0;
   logic       drv_par_en  = 1'b0;
   logic       drv_par_typ = 1'b0;
   logic       sel         = 1'b0;

   uart_tx_serializer_if #(.DATA_WIDTH(8)) if8 ();
   uart_tx_serializer_if #(.DATA_WIDTH(5)) if5 ();

   assign if8.p_data     = drv_data;
   assign if8.data_valid = drv_valid & ~sel;
   assign if8.par_en     = drv_par_en;
   assign if8.par_typ    = drv_par_typ;
   assign if5.p_data     = drv_data[4:0];
   assign if5.data_valid = drv_valid & sel;
   assign if5.par_en     = drv_par_en;
   assign if5.par_typ    = drv_par_typ;

   uart_tx_serializer #(.DATA_WIDTH(8)) dut8 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (if8.slave)
   );

   uart_tx_serializer #(.DATA_WIDTH(5)) dut5 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (if5.slave)
   );

   logic mon_tx, mon_busy;
   assign mon_tx   = sel ? if5.tx_out : if8.tx_out;
   assign mon_busy = sel ? if5.busy   : if8.busy;

   int     tests = 0;
   int     fails = 0;
   frame_t exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Line image of a frame: bit i is the level during bit period i.
   function automatic frame_t mk(input logic [7:0] d, input int w, input bit pe,
                                 input bit pb, input int gap, input bit ab);
      frame_t f;
      int     idx;
      f.bits    = '0;
      f.bits[0] = 1'b0;
      for (int i = 0; i < w; i++) f.bits[1+i] = d[i];
      idx = w + 1;
      if (pe) begin
         f.bits[idx] = pb;
         idx++;
      end
      f.bits[idx] = 1'b1;
      f.len   = idx + 1;
      f.gap   = gap;
      f.abort = ab;
      return f;
   endfunction

   task automatic send(input logic [7:0] d, input bit pe, input bit pt, input frame_t f);
      exp_q.push_back(f);
      @(negedge clk);
      drv_data    = d;
      drv_par_en  = pe;
      drv_par_typ = pt;
      drv_valid   = 1'b1;
      @(negedge clk);
      drv_valid   = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (mon_busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s: busy still %0b after %0d cycles, expected 0", name, mon_busy, n);
      end
      @(negedge clk);
   endtask

   // Monitor: a low line level in idle marks a start bit.
   initial begin
      frame_t      f;
      logic [15:0] got;
      int          busy_cnt;
      int          idle_cnt;
      int          nframe;
      bit          ab;
      idle_cnt = 0;
      nframe   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            idle_cnt = 0;
         end else if (mon_tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_frame: got start bit, expected idle line");
            end else begin
               f        = exp_q.pop_front();
               got      = '0;
               busy_cnt = (mon_busy === 1'b1) ? 1 : 0;
               ab       = 1'b0;
               for (int i = 1; i < f.len; i++) begin
                  @(negedge clk);
                  if (!rst_n) begin
                     ab = 1'b1;
                     break;
                  end
                  got[i] = mon_tx;
                  if (mon_busy === 1'b1) busy_cnt++;
               end
               nframe++;
               if (f.gap >= 0) check("gap_cycles", idle_cnt, f.gap);
               check("frame_aborted", {31'd0, ab}, {31'd0, f.abort});
               if (!ab) begin
                  check("frame_bits", {16'd0, got}, {16'd0, f.bits});
                  check("busy_cycles", busy_cnt, f.len);
                  @(negedge clk);
                  check("post_frame_line", {30'd0, mon_tx, mon_busy}, {30'd0, 1'b1, 1'b0});
                  idle_cnt = 1;
               end else begin
                  idle_cnt = 0;
               end
               $display("[TB] frame %0d: len=%0d expected_bits=%04h got_bits=%04h aborted=%0b",
                        nframe, f.len, f.bits, got, ab);
            end
         end else begin
            idle_cnt++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      repeat (2) @(negedge clk);
      check("reset_tx_busy", {30'd0, if8.tx_out, if8.busy}, {30'd0, 1'b1, 1'b0});
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_tx_busy", {30'd0, if8.tx_out, if8.busy}, {30'd0, 1'b1, 1'b0});

      // 0xA5 without parity, then even and odd parity (four ones).
      send(8'hA5, 1'b0, PAR_EVEN, mk(8'hA5, 8, 1'b0, 1'b0, -1, 1'b0)); wait_idle("wait_a5");
      send(8'hA5, 1'b1, PAR_EVEN, mk(8'hA5, 8, 1'b1, 1'b0, -1, 1'b0)); wait_idle("wait_a5e");
      send(8'hA5, 1'b1, PAR_ODD,  mk(8'hA5, 8, 1'b1, 1'b1, -1, 1'b0)); wait_idle("wait_a5o");
      send(8'h07, 1'b1, PAR_EVEN, mk(8'h07, 8, 1'b1, 1'b1, -1, 1'b0)); wait_idle("wait_07e");
      send(8'h00, 1'b1, PAR_ODD,  mk(8'h00, 8, 1'b1, 1'b1, -1, 1'b0)); wait_idle("wait_00o");
      send(8'hFF, 1'b1, PAR_EVEN, mk(8'hFF, 8, 1'b1, 1'b0, -1, 1'b0)); wait_idle("wait_ffe");

      // Valid held high with data/config changing every cycle: accepts land at cycles 0, 11, 22.
      exp_q.push_back(mk(8'h30, 8, 1'b0, 1'b0, -1, 1'b0));
      exp_q.push_back(mk(8'h3B, 8, 1'b0, 1'b0,  1, 1'b0));
      exp_q.push_back(mk(8'h46, 8, 1'b0, 1'b0,  1, 1'b0));
      for (int k = 0; k < 23; k++) begin
         @(negedge clk);
         drv_data    = 8'h30 + 8'(k);
         drv_par_en  = (k % 11) != 0;
         drv_par_typ = k[0];
         drv_valid   = 1'b1;
      end
      @(negedge clk);
      drv_valid = 1'b0;
      wait_idle("wait_b2b");

      // Reset during data bit 3 of 0x5A.
      send(8'h5A, 1'b0, PAR_EVEN, mk(8'h5A, 8, 1'b0, 1'b0, -1, 1'b1));
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_tx_busy", {30'd0, if8.tx_out, if8.busy}, {30'd0, 1'b1, 1'b0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (if8.tx_out !== 1'b1 || if8.busy !== 1'b0) bad = 1'b1;
      end
      check("idle_after_reset", {31'd0, bad}, 32'd0);
      send(8'h3C, 1'b1, PAR_ODD, mk(8'h3C, 8, 1'b1, 1'b1, -1, 1'b0)); wait_idle("wait_3c");

      // Five-bit payload: 0x15 has three ones, even parity bit is 1.
      sel = 1'b1;
      repeat (2) @(negedge clk);
      send(8'h15, 1'b1, PAR_EVEN, mk(8'h15, 5, 1'b1, 1'b1, -1, 1'b0)); wait_idle("wait_w5");

      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
